// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and its HID translation.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_LEFT  = 8'h50;

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// PS/2 bus lines plus the receiver's result signals, bundled for host-side wiring.
interface ps2_keycode_rx_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] keycode;
    logic [7:0] keycode2;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       key_event;
    logic       frame_err;

    modport master (
        output ps2_clk, ps2_data,
        input  keycode, keycode2, rx_byte, rx_valid, key_event, frame_err
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output keycode, keycode2, rx_byte, rx_valid, key_event, frame_err
    );
endinterface

// File: rtl/ps2_to_hid.sv
// Scan-code to HID usage LUT; index bit 8 is the E0 extended prefix.
module ps2_to_hid
    import ps2_pkg::*;
(
    input  logic [8:0] code_i,
    output logic [7:0] usage_o
);

    always_comb begin
        usage_o = HID_NONE;
        case (code_i)
            9'h01C:  usage_o = HID_A;
            9'h023:  usage_o = HID_D;
            9'h01D:  usage_o = HID_W;
            9'h01B:  usage_o = HID_S;
            9'h029:  usage_o = HID_SPACE;
            9'h05A:  usage_o = HID_ENTER;
            9'h16B:  usage_o = HID_LEFT;
            9'h174:  usage_o = HID_RIGHT;
            default: usage_o = HID_NONE;
        endcase
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard receiver: synchronise/filter the bus, frame scan bytes,
// and track up to two held keys as HID usage codes.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 5000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic [7:0] keycode2,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       key_event,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    if (CLK_HZ < 1_000_000 || FILTER_LEN < 2 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("ps2_keycode_rx: unsupported parameter set");
    end

    logic [1:0]    clk_sync_q, dat_sync_q;
    logic          filt_q;
    logic [FW-1:0] flt_cnt_q;
    logic          fall_edge;

    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q, rx_byte_q;
    logic          par_q, rx_valid_q, frame_err_q;
    logic [TW-1:0] to_cnt_q;

    logic          ext_q, brk_q, key_event_q;
    logic [7:0]    key1_q, key2_q, key1_d, key2_d, usage;

    // Synchronisers idle high so reset looks like an idle bus.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
        end else if (clk_sync_q[1] == filt_q) begin
            flt_cnt_q <= '0;
        end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_q    <= clk_sync_q[1];
            flt_cnt_q <= '0;
        end else begin
            flt_cnt_q <= flt_cnt_q + 1'b1;
        end
    end

    assign fall_edge = filt_q && !clk_sync_q[1] && (flt_cnt_q == FW'(FILTER_LEN - 1));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            to_cnt_q    <= '0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            if (state_q != ST_IDLE && !fall_edge && to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_q     <= ST_IDLE;
                frame_err_q <= 1'b1;
                to_cnt_q    <= '0;
            end else begin
                to_cnt_q <= (fall_edge || state_q == ST_IDLE) ? '0 : to_cnt_q + 1'b1;
                if (fall_edge) begin
                    case (state_q)
                        ST_IDLE: if (!dat_sync_q[1]) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= '0;
                        end
                        ST_DATA: begin
                            shift_q   <= {dat_sync_q[1], shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                        end
                        ST_PARITY: begin
                            par_q   <= dat_sync_q[1];
                            state_q <= ST_STOP;
                        end
                        ST_STOP: begin
                            if (dat_sync_q[1] && ^{shift_q, par_q}) begin
                                rx_byte_q  <= shift_q;
                                rx_valid_q <= 1'b1;
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                            state_q <= ST_IDLE;
                        end
                        default: state_q <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    ps2_to_hid u_lut (
        .code_i  ({ext_q, rx_byte_q}),
        .usage_o (usage)
    );

    // keycode2 is only ever non-zero while keycode is, so a break of slot 1 shifts slot 2 down.
    always_comb begin
        key1_d = key1_q;
        key2_d = key2_q;
        if (usage != HID_NONE) begin
            if (brk_q) begin
                if (usage == key2_q) begin
                    key2_d = HID_NONE;
                end else if (usage == key1_q) begin
                    key1_d = key2_q;
                    key2_d = HID_NONE;
                end
            end else if (usage != key1_q && usage != key2_q) begin
                if (key1_q == HID_NONE)      key1_d = usage;
                else if (key2_q == HID_NONE) key2_d = usage;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key1_q      <= HID_NONE;
            key2_q      <= HID_NONE;
            key_event_q <= 1'b0;
        end else begin
            key_event_q <= 1'b0;
            if (frame_err_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (rx_valid_q) begin
                if (rx_byte_q == PS2_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_byte_q == PS2_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    ext_q       <= 1'b0;
                    brk_q       <= 1'b0;
                    key1_q      <= key1_d;
                    key2_q      <= key2_d;
                    key_event_q <= (key1_d != key1_q) || (key2_d != key2_q);
                end
            end
        end
    end

    assign keycode   = key1_q;
    assign keycode2  = key2_q;
    assign rx_byte   = rx_byte_q;
    assign rx_valid  = rx_valid_q;
    assign key_event = key_event_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed bench for ps2_keycode_rx: framing, slot tracking, errors, timeout, reset.
module tb_ps2_keycode_rx;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #10 Clk = ~Clk;

    ps2_keycode_rx_if bus ();

    ps2_keycode_rx dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .ps2_clk   (bus.ps2_clk),
        .ps2_data  (bus.ps2_data),
        .keycode   (bus.keycode),
        .keycode2  (bus.keycode2),
        .rx_byte   (bus.rx_byte),
        .rx_valid  (bus.rx_valid),
        .key_event (bus.key_event),
        .frame_err (bus.frame_err)
    );

    localparam int H = 20;  // PS/2 half-period in Clk cycles

    int checks = 0;
    int errors = 0;
    int rv_n = 0, ke_n = 0, fe_n = 0;
    int rv0, ke0, fe0;

    always @(negedge Clk) begin
        if (bus.rx_valid)  rv_n++;
        if (bus.key_event) ke_n++;
        if (bus.frame_err) fe_n++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge Clk);
    endtask

    task automatic ps2_bit(input logic b);
        bus.ps2_data = b;
        wait_clk(H);
        bus.ps2_clk = 1'b0;
        wait_clk(H);
        bus.ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit good);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(good ? ~^b : ^b);
        ps2_bit(1'b1);
        wait_clk(2 * H);
        @(negedge Clk);
    endtask

    task automatic snap();
        rv0 = rv_n; ke0 = ke_n; fe0 = fe_n;
    endtask

    task automatic test_reset();
        bus.ps2_clk = 1'b1; bus.ps2_data = 1'b1; Reset_n = 1'b0;
        wait_clk(5); @(negedge Clk);
        checks++; if (bus.keycode !== 8'h00)  begin errors++; $display("FAIL reset_keycode got %h exp 00", bus.keycode); end
        checks++; if (bus.keycode2 !== 8'h00) begin errors++; $display("FAIL reset_keycode2 got %h exp 00", bus.keycode2); end
        checks++; if (bus.rx_byte !== 8'h00)  begin errors++; $display("FAIL reset_rx_byte got %h exp 00", bus.rx_byte); end
        checks++; if ({bus.rx_valid, bus.key_event, bus.frame_err} !== 3'b000)
            begin errors++; $display("FAIL reset_pulses got %b exp 000", {bus.rx_valid, bus.key_event, bus.frame_err}); end
        Reset_n = 1'b1;
        wait_clk(20);
    endtask

    task automatic test_single_make();
        snap();
        send_frame(8'h1C, 1'b1);
        checks++; if (bus.rx_byte !== 8'h1C) begin errors++; $display("FAIL make_rx_byte got %h exp 1c", bus.rx_byte); end
        checks++; if (rv_n - rv0 !== 1)      begin errors++; $display("FAIL make_rx_valid pulses got %0d exp 1", rv_n - rv0); end
        checks++; if (bus.keycode !== 8'h04) begin errors++; $display("FAIL make_keycode got %h exp 04", bus.keycode); end
        checks++; if (ke_n - ke0 !== 1)      begin errors++; $display("FAIL make_key_event pulses got %0d exp 1", ke_n - ke0); end
        checks++; if (fe_n - fe0 !== 0)      begin errors++; $display("FAIL make_frame_err pulses got %0d exp 0", fe_n - fe0); end
    endtask

    task automatic test_two_slots();
        snap();
        send_frame(8'h23, 1'b1);
        send_frame(8'h1D, 1'b1);
        checks++; if (bus.keycode !== 8'h04)  begin errors++; $display("FAIL slots_keycode got %h exp 04", bus.keycode); end
        checks++; if (bus.keycode2 !== 8'h07) begin errors++; $display("FAIL slots_keycode2 got %h exp 07", bus.keycode2); end
        checks++; if (ke_n - ke0 !== 1)       begin errors++; $display("FAIL slots_key_event pulses got %0d exp 1", ke_n - ke0); end
        snap();
        send_frame(8'h1C, 1'b1);
        send_frame(8'h15, 1'b1);
        checks++; if (bus.rx_byte !== 8'h15) begin errors++; $display("FAIL unmapped_rx_byte got %h exp 15", bus.rx_byte); end
        checks++; if (rv_n - rv0 !== 2)      begin errors++; $display("FAIL dup_unmapped_rx_valid got %0d exp 2", rv_n - rv0); end
        checks++; if (ke_n - ke0 !== 0)      begin errors++; $display("FAIL dup_unmapped_key_event got %0d exp 0", ke_n - ke0); end
        checks++; if ({bus.keycode, bus.keycode2} !== 16'h0407)
            begin errors++; $display("FAIL dup_unmapped_slots got %h exp 0407", {bus.keycode, bus.keycode2}); end
    endtask

    task automatic test_break();
        snap();
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b1);
        checks++; if ({bus.keycode, bus.keycode2} !== 16'h0700)
            begin errors++; $display("FAIL break_compact got %h exp 0700", {bus.keycode, bus.keycode2}); end
        checks++; if (ke_n - ke0 !== 1) begin errors++; $display("FAIL break_key_event got %0d exp 1", ke_n - ke0); end
        snap();
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b1);
        checks++; if ({bus.keycode, bus.keycode2} !== 16'h0700)
            begin errors++; $display("FAIL break_unheld got %h exp 0700", {bus.keycode, bus.keycode2}); end
        checks++; if (ke_n - ke0 !== 0) begin errors++; $display("FAIL break_unheld_key_event got %0d exp 0", ke_n - ke0); end
    endtask

    task automatic test_extended();
        send_frame(8'hF0, 1'b1);
        send_frame(8'h23, 1'b1);
        checks++; if (bus.keycode !== 8'h00) begin errors++; $display("FAIL ext_pre_clear got %h exp 00", bus.keycode); end
        send_frame(8'hE0, 1'b1);
        send_frame(8'h74, 1'b1);
        checks++; if (bus.keycode !== 8'h4F) begin errors++; $display("FAIL ext_make_right got %h exp 4f", bus.keycode); end
        snap();
        send_frame(8'hE0, 1'b1);
        send_frame(8'hF0, 1'b1);
        send_frame(8'h74, 1'b1);
        checks++; if (bus.keycode !== 8'h00) begin errors++; $display("FAIL ext_break_right got %h exp 00", bus.keycode); end
        checks++; if (ke_n - ke0 !== 1)      begin errors++; $display("FAIL ext_break_key_event got %0d exp 1", ke_n - ke0); end
    endtask

    task automatic test_parity_err();
        send_frame(8'h1C, 1'b1);
        snap();
        send_frame(8'h29, 1'b0);
        checks++; if (fe_n - fe0 !== 1)      begin errors++; $display("FAIL parity_frame_err got %0d exp 1", fe_n - fe0); end
        checks++; if (rv_n - rv0 !== 0)      begin errors++; $display("FAIL parity_rx_valid got %0d exp 0", rv_n - rv0); end
        checks++; if (bus.rx_byte !== 8'h1C) begin errors++; $display("FAIL parity_rx_byte got %h exp 1c", bus.rx_byte); end
        checks++; if ({bus.keycode, bus.keycode2} !== 16'h0400)
            begin errors++; $display("FAIL parity_slots got %h exp 0400", {bus.keycode, bus.keycode2}); end
        // A pending break must be dropped by the bad frame, so 23 acts as a make.
        send_frame(8'hF0, 1'b1);
        send_frame(8'h00, 1'b0);
        send_frame(8'h23, 1'b1);
        checks++; if ({bus.keycode, bus.keycode2} !== 16'h0407)
            begin errors++; $display("FAIL err_clears_brk got %h exp 0407", {bus.keycode, bus.keycode2}); end
    endtask

    task automatic test_timeout();
        snap();
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        bus.ps2_data = 1'b1;
        wait_clk(6000); @(negedge Clk);
        checks++; if (fe_n - fe0 !== 1) begin errors++; $display("FAIL timeout_frame_err got %0d exp 1", fe_n - fe0); end
        checks++; if (dut.state_q !== ps2_pkg::ST_IDLE) begin errors++; $display("FAIL timeout_idle got %0d exp 0", dut.state_q); end
        send_frame(8'hF0, 1'b1);
        send_frame(8'h1C, 1'b1);
        checks++; if ({bus.keycode, bus.keycode2} !== 16'h0700)
            begin errors++; $display("FAIL timeout_resume got %h exp 0700", {bus.keycode, bus.keycode2}); end
    endtask

    task automatic test_reset_midframe();
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b0);
        bus.ps2_data = 1'b1;
        Reset_n = 1'b0;
        wait_clk(3); @(negedge Clk);
        checks++; if ({bus.keycode, bus.keycode2, bus.rx_byte} !== 24'h000000)
            begin errors++; $display("FAIL midreset_bytes got %h exp 000000", {bus.keycode, bus.keycode2, bus.rx_byte}); end
        checks++; if ({bus.rx_valid, bus.key_event, bus.frame_err} !== 3'b000)
            begin errors++; $display("FAIL midreset_pulses got %b exp 000", {bus.rx_valid, bus.key_event, bus.frame_err}); end
        Reset_n = 1'b1;
        wait_clk(20);
        snap();
        send_frame(8'h23, 1'b1);
        checks++; if (bus.keycode !== 8'h07) begin errors++; $display("FAIL midreset_keycode got %h exp 07", bus.keycode); end
        checks++; if (bus.rx_byte !== 8'h23) begin errors++; $display("FAIL midreset_rx_byte got %h exp 23", bus.rx_byte); end
        checks++; if (fe_n - fe0 !== 0)      begin errors++; $display("FAIL midreset_frame_err got %0d exp 0", fe_n - fe0); end
    endtask

    initial begin
        test_reset();
        test_single_make();
        test_two_slots();
        test_break();
        test_extended();
        test_parity_err();
        test_timeout();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_keycode_rx.md
PS2_KEYCODE_RX -- requirements
Module: ps2_keycode_rx

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter FILTER_LEN, default 8, number of consecutive equal samples that define a stable PS/2 clock level.
REQ-003 Parameter TIMEOUT_CYC, default 5000, idle-high Clk cycles (100 us) after which a partial frame is aborted.
REQ-004 Clk  input  1  system clock (MAX10_CLK1_50 domain); one clock only.
REQ-005 Reset_n  input  1  reset, asynchronous and active-low.
REQ-006 ps2_clk  input  1  PS/2 clock line (asynchronous to Clk).
REQ-007 ps2_data  input  1  PS/2 data line (asynchronous to Clk).
REQ-008 keycode  output  8  first held key as a USB HID usage code; 0x00 when no key is held.
REQ-009 keycode2  output  8  second held key as a USB HID usage code; 0x00 when no second key is held.
REQ-010 rx_byte  output  8  last correctly framed scan byte.
REQ-011 rx_valid  output  1  one-Clk pulse when rx_byte updates.
REQ-012 key_event  output  1  one-Clk pulse when keycode or keycode2 changes.
REQ-013 frame_err  output  1  one-Clk pulse on a parity, start, stop or timeout error.

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; the filtered ps2_clk level SHALL change only after FILTER_LEN equal synchronized samples.
REQ-015 A bit SHALL be sampled from synchronized ps2_data on each filtered ps2_clk falling edge.
REQ-016 The receive FSM states SHALL be IDLE, DATA, PARITY and STOP.
REQ-017 IDLE: a sample of 1 stays in IDLE; a sample of 0 (start bit) goes to DATA with the bit counter at 0.
REQ-018 DATA: the FSM SHALL shift in 8 bits LSB first, then go to PARITY.
REQ-019 PARITY: the FSM SHALL store the sampled bit, then go to STOP; the frame is valid only if data plus parity has odd weight.
REQ-020 STOP: a sample of 1 with valid parity SHALL load rx_byte and pulse rx_valid in the next Clk; any other case SHALL pulse frame_err. The FSM returns to IDLE in both cases.
REQ-021 In any state other than IDLE, TIMEOUT_CYC cycles without a falling edge SHALL pulse frame_err and force IDLE.
REQ-022 Byte decode: 0xE0 sets ext_pending; 0xF0 sets brk_pending; any other byte is a key byte and clears both flags after use.
REQ-023 A key byte SHALL be translated through a LUT indexed by {ext_pending, byte}:
  - 0x1C->0x04 (A), 0x23->0x07 (D), 0x1D->0x1A (W), 0x1B->0x16 (S)
  - 0x29->0x2C (Space), 0x5A->0x28 (Enter)
  - E0 0x6B->0x50 (Left), E0 0x74->0x4F (Right)
  - every other code maps to 0x00 and is ignored with no slot change.
REQ-024 Make of usage U already in a slot: no change.
REQ-025 Make with keycode==0x00: keycode<=U. Otherwise, with keycode2==0x00: keycode2<=U. Both slots full: U is dropped.
REQ-026 Break of U in keycode2: keycode2<=0x00.
REQ-027 Break of U in keycode: keycode<=keycode2 and keycode2<=0x00 (compaction).
REQ-028 Break of a U that is not held: no change.
REQ-029 The slot update SHALL occur in the Clk after rx_valid, so key latency is 2 Clk after the stop-bit edge; key_event SHALL pulse in that same cycle only if a slot value changed.
REQ-030 A frame error SHALL clear ext_pending and brk_pending and leave the slots unchanged.

Reset
REQ-031 While Reset_n=0, the FSM SHALL be IDLE and the counters and flags SHALL be 0.
REQ-032 While Reset_n=0, keycode, keycode2 and rx_byte SHALL be 0x00 and rx_valid, key_event and frame_err SHALL be 0.
REQ-033 The synchronizers SHALL reset to 1 (bus idle).
REQ-034 Reset asserted mid-frame SHALL discard the partial frame; reception SHALL resume with the next start bit after release.

Structure
REQ-035 Package ps2_pkg SHALL hold the FSM state enum, the constants PS2_EXT=0xE0 and PS2_BRK=0xF0, and the HID usage constants.
REQ-036 Sub-module ps2_to_hid SHALL be a combinational LUT (9-bit in, 8-bit out); the module's top-level port list is keycode/keycode2-compatible and drops into the existing keycode inputs of the game modules.

Verification
REQ-037 Frame 0x1C with parity 0 -> rx_byte=0x1C, rx_valid 1 pulse, keycode=0x04, key_event 1 pulse.
REQ-038 Make A, make D, make W -> keycode=0x04, keycode2=0x07; W is dropped.
REQ-039 Then F0 1C -> keycode=0x07, keycode2=0x00; then F0 1C again -> no change and no key_event.
REQ-040 E0 74 then E0 F0 74 -> keycode goes 0x4F then 0x00.
REQ-041 Frame 0x29 with wrong parity -> frame_err pulse and slots unchanged; 4 bits then 6000 idle cycles -> frame_err pulse and FSM back in IDLE.
REQ-042 Reset_n pulsed low after 5 bits of a frame -> all outputs 0x00/0; the next full frame 0x23 -> keycode=0x07.
